// File: rtl/feedback_synchronizer.sv
// Carries single-cycle events from the send clock domain to the receive clock domain
// using a four-phase req/ack level handshake and a one-deep pending buffer on the send side.
`timescale 1ns / 1ps

module feedback_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic in_clk_send,
   input  logic in_reset_send,
   input  logic in_clk_receive,
   input  logic in_reset_receive,
   input  logic in_data,
   output logic out_data
);

   // ---------------- send domain ----------------
   logic                   in_data_q, in_data_d;
   logic                   armed_q, armed_d;
   logic                   req_q, req_d;
   logic                   pending_q, pending_d;
   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_STAGES-1:0] ack_chain_q;
   logic [SYNC_STAGES-1:0] ack_chain_d;
   logic                   ack;
   logic                   busy;
   logic                   event_s;

   // ---------------- receive domain ----------------
   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_STAGES-1:0] req_chain_q;
   logic [SYNC_STAGES-1:0] req_chain_d;
   logic                   req_sync;
   logic                   req_sync_dly_q, req_sync_dly_d;
   logic                   out_data_q, out_data_d;

   assign ack      = ack_chain_q[SYNC_STAGES-1];
   assign busy     = req_q | ack;
   // armed_q stays low until a 0 has been sampled, so a level already high at reset release is not an event
   assign event_s  = in_data & ~in_data_q & armed_q;
   assign req_sync = req_chain_q[SYNC_STAGES-1];
   assign out_data = out_data_q;

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      in_data_d   = in_data;
      armed_d     = armed_q | ~in_data;
      ack_chain_d = {ack_chain_q[SYNC_STAGES-2:0], req_sync};
      req_d       = req_q;
      pending_d   = pending_q;
      if (busy) begin
         if (ack) begin
            req_d = 1'b0;
         end
         if (event_s) begin
            pending_d = 1'b1;
         end
      end else begin
         // Idle: launch the buffered event first; a simultaneous new event takes its slot.
         req_d     = pending_q | event_s;
         pending_d = pending_q & event_s;
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so busy is always judged on pre-edge values.
   always_ff @(posedge in_clk_send or posedge in_reset_send) begin
      if (in_reset_send) begin
         in_data_q   <= 1'b0;
         armed_q     <= 1'b0;
         req_q       <= 1'b0;
         pending_q   <= 1'b0;
         ack_chain_q <= '0;
      end else begin
         in_data_q   <= in_data_d;
         armed_q     <= armed_d;
         req_q       <= req_d;
         pending_q   <= pending_d;
         ack_chain_q <= ack_chain_d;
      end
   end

   always_comb begin
      req_chain_d    = {req_chain_q[SYNC_STAGES-2:0], req_q};
      req_sync_dly_d = req_sync;
      out_data_d     = req_sync & ~req_sync_dly_q;
   end

   always_ff @(posedge in_clk_receive or posedge in_reset_receive) begin
      if (in_reset_receive) begin
         req_chain_q    <= '0;
         req_sync_dly_q <= 1'b0;
         out_data_q     <= 1'b0;
      end else begin
         req_chain_q    <= req_chain_d;
         req_sync_dly_q <= req_sync_dly_d;
         out_data_q     <= out_data_d;
      end
   end

endmodule

// File: tb/tb_feedback_synchronizer.sv
// Directed bench for feedback_synchronizer: send clock 10 ns, receive clock 22 ns.
// Expected pulses are queued when stimulus is driven and consumed by a receive-side monitor.
`timescale 1ns / 1ps

module tb_feedback_synchronizer;

   localparam int SYNC_STAGES = 2;
   // Frame start fixes each frame's cycle-75 handshake to a receive phase where it ends
   // by cycle 87; slower phases stretch it and the cycle-87 event would be dropped.
   localparam int FRAME_BASE  = 801;

   logic in_clk_send      = 1'b0;
   logic in_clk_receive   = 1'b0;
   logic in_reset_send    = 1'b0;
   logic in_reset_receive = 1'b0;
   logic in_data          = 1'b0;
   logic out_data;

   int   n_checks  = 0;
   int   n_fail    = 0;
   int   edges     = 0;
   int   pulse_cnt = 0;
   int   cur_tag   = 0;
   int   sb[$];
   logic prev_out  = 1'b0;

   feedback_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .in_clk_send      (in_clk_send),
      .in_reset_send    (in_reset_send),
      .in_clk_receive   (in_clk_receive),
      .in_reset_receive (in_reset_receive),
      .in_data          (in_data),
      .out_data         (out_data)
   );

   // Send rises at 5+10n, receive at 14+22m: edges never coincide.
   initial forever #5 in_clk_send = ~in_clk_send;
   initial begin
      #3;
      forever #11 in_clk_receive = ~in_clk_receive;
   end

   always @(posedge in_clk_send) edges <= edges + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Waits to the falling edge just before send edge n, so a value driven now is sampled there.
   task automatic go(input int n);
      while (edges < n) @(negedge in_clk_send);
   endtask

   task automatic pulse(input int at, input int len);
      go(at);
      in_data = 1'b1;
      go(at + len);
      in_data = 1'b0;
   endtask

   task automatic expect_pulses(input int tag, input int n);
      cur_tag = tag;
      for (int i = 0; i < n; i++) sb.push_back(tag);
   endtask

   task automatic close_scenario(input string name, input int exp, input int start, input int drain_to);
      go(drain_to);
      check({name, "_pulses"}, pulse_cnt - start, exp);
      check({name, "_sb_empty"}, sb.size(), 0);
   endtask

   always @(negedge in_clk_receive) begin
      if (prev_out === 1'b1) check("pulse_width", out_data, 1'b0);
      if (out_data === 1'b1 && prev_out === 1'b0) begin
         pulse_cnt <= pulse_cnt + 1;
         check("pulse_expected", sb.size() > 0, 1'b1);
         if (sb.size() > 0) check("pulse_tag", cur_tag, sb.pop_front());
      end
      prev_out <= out_data;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int lat;
      in_reset_send    = 1'b1;
      in_reset_receive = 1'b1;
      #1;
      check("reset_out_data", out_data, 1'b0);
      @(negedge in_clk_receive);
      in_reset_receive = 1'b0;
      go(3);
      in_reset_send = 1'b0;
      go(15);
      check("idle_after_reset", pulse_cnt, 0);

      // Single pulse and its latency in receive edges after req rises.
      start = pulse_cnt;
      expect_pulses(1, 1);
      go(20);
      in_data = 1'b1;
      @(posedge in_clk_send);
      #1 in_data = 1'b0;
      lat = 0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(posedge in_clk_receive);
         #1;
         if (out_data === 1'b1) lat = i;
      end
      check("latency_rx_edges", lat, SYNC_STAGES + 1);
      close_scenario("single", 1, start, 80);

      // Second event lands in the pending buffer.
      start = pulse_cnt;
      expect_pulses(2, 2);
      pulse(140, 1);
      pulse(142, 1);
      close_scenario("two_events", 2, start, 220);

      // Seven-cycle level is one event.
      start = pulse_cnt;
      expect_pulses(3, 1);
      pulse(275, 7);
      close_scenario("level", 1, start, 320);

      // Third event while busy with a full buffer is dropped.
      start = pulse_cnt;
      expect_pulses(4, 2);
      pulse(340, 1);
      pulse(342, 1);
      pulse(344, 1);
      close_scenario("drop_third", 2, start, 420);

      // Level high across send-reset release is not an event; the next clean rise is.
      start = pulse_cnt;
      expect_pulses(5, 1);
      go(430);
      in_data       = 1'b1;
      in_reset_send = 1'b1;
      go(433);
      in_reset_send = 1'b0;
      go(440);
      in_data = 1'b0;
      pulse(445, 1);
      close_scenario("high_at_reset", 1, start, 500);

      // Abort mid-handshake, send reset released first.
      start = pulse_cnt;
      expect_pulses(6, 0);
      pulse(520, 1);
      go(522);
      #3;
      in_reset_send    = 1'b1;
      in_reset_receive = 1'b1;
      #1 check("abort_a_out_in_reset", out_data, 1'b0);
      #14 in_reset_send = 1'b0;
      @(negedge in_clk_receive);
      in_reset_receive = 1'b0;
      close_scenario("abort_a", 0, start, 560);
      start = pulse_cnt;
      expect_pulses(7, 1);
      pulse(570, 1);
      close_scenario("after_abort_a", 1, start, 620);

      // Abort mid-handshake, receive reset released first.
      start = pulse_cnt;
      expect_pulses(8, 0);
      pulse(640, 1);
      go(642);
      #3;
      in_reset_send    = 1'b1;
      in_reset_receive = 1'b1;
      #1 check("abort_b_out_in_reset", out_data, 1'b0);
      #14;
      @(negedge in_clk_receive);
      in_reset_receive = 1'b0;
      #7 in_reset_send = 1'b0;
      close_scenario("abort_b", 0, start, 700);
      start = pulse_cnt;
      expect_pulses(9, 1);
      pulse(710, 1);
      close_scenario("after_abort_b", 1, start, 760);

      // Three 100-cycle frames, six delivered events each.
      start = pulse_cnt;
      for (int k = 0; k < 3; k++) begin
         expect_pulses(10, 6);
         pulse(FRAME_BASE + 100 * k + 5, 1);
         pulse(FRAME_BASE + 100 * k + 40, 1);
         pulse(FRAME_BASE + 100 * k + 42, 1);
         pulse(FRAME_BASE + 100 * k + 75, 7);
         pulse(FRAME_BASE + 100 * k + 85, 1);
         pulse(FRAME_BASE + 100 * k + 87, 1);
      end
      close_scenario("frames", 18, start, FRAME_BASE + 370);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
